mpsoc_msi_wb_arbiter: RTL and testbench



---
 rtl/mpsoc_msi_wb_arbiter_if.sv | 53 +++++
 rtl/mpsoc_msi_wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_mpsoc_msi_wb_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpsoc_msi_wb_arbiter_if.sv
// Bundle of every Wishbone signal that crosses the arbiter: the NM
// master-side ports (flattened, master k at slice k) and the single
// slave-side port. The arbiter connects through the 'slave' modport
// because it serves the masters' requests. The 'master' modport is the
// environment's view: it drives the masters' requests and the slave's
// responses.
interface mpsoc_msi_wb_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int NM = 3
);
  // master side
  logic [NM*AW-1:0] m_adr_i;
  logic [NM*DW-1:0] m_dat_i;
  logic [NM*4-1:0]  m_sel_i;
  logic [NM-1:0]    m_we_i;
  logic [NM-1:0]    m_cyc_i;
  logic [NM-1:0]    m_stb_i;
  logic [NM*3-1:0]  m_cti_i;
  logic [NM*2-1:0]  m_bte_i;
  logic [DW-1:0]    m_dat_o;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;
  logic [NM-1:0]    m_rty_o;

  // slave side
  logic [AW-1:0]    s_adr_o;
  logic [DW-1:0]    s_dat_o;
  logic [3:0]       s_sel_o;
  logic             s_we_o;
  logic             s_cyc_o;
  logic             s_stb_o;
  logic [2:0]       s_cti_o;
  logic [1:0]       s_bte_o;
  logic [DW-1:0]    s_dat_i;
  logic             s_ack_i;
  logic             s_err_i;
  logic             s_rty_i;

  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i
  );

  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i
  );
endinterface

// File: rtl/mpsoc_msi_wb_arbiter.sv
// Round-robin Wishbone B3 arbiter: NM masters share one slave bus.
// - The grant is held for the whole cyc, so bursts are never split.
// - The last winner gets the lowest priority in the next round.
// - A watchdog ends a transfer with an error when the slave stalls
//   for TIMEOUT cycles.
module mpsoc_msi_wb_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NM      = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  mpsoc_msi_wb_arbiter_if.slave  bus,
  output logic [NM-1:0]          grant_o,
  output logic                   timeout_o
);

  localparam int LW = (NM > 1) ? $clog2(NM) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TOUT  = 2'd2
  } state_t;

  state_t        state;
  logic [LW-1:0] last;
  logic [TW-1:0] tcnt;
  logic [LW-1:0] winner;
  logic          gcyc;
  logic          gstb;
  logic          s_resp;
  logic          stall;

  // First requester found when scanning last+1, last+2, ... modulo NM.
  // The loop walks the offsets backwards so that the smallest offset
  // with a request overwrites all the others.
  function automatic logic [LW-1:0] rr_pick(input logic [NM-1:0] req,
                                            input logic [LW-1:0] prev);
    logic [LW-1:0] pick;
    logic [LW:0]   idx;
    pick = prev;
    for (int i = NM; i >= 1; i--) begin
      idx = {1'b0, prev} + (LW+1)'(i);
      if (idx >= (LW+1)'(NM)) idx = idx - (LW+1)'(NM);
      if (req[idx[LW-1:0]]) pick = idx[LW-1:0];
    end
    return pick;
  endfunction

  // Round-robin winner candidate and the granted master's cyc/stb.
  always_comb begin
    winner = rr_pick(bus.m_cyc_i, last);
    gcyc   = |(bus.m_cyc_i & grant_o);
    gstb   = |(bus.m_stb_i & grant_o);
    s_resp = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
    stall  = gstb & ~s_resp;
  end

  // Slave-side mux. It is zero whenever nobody is granted, which also
  // covers the reset values. cyc/stb reach the slave only in GRANT, so
  // they drop in the same cycle that the granted master drops cyc.
  always_comb begin
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.s_we_o  = 1'b0;
    bus.s_cti_o = '0;
    bus.s_bte_o = '0;
    for (int k = 0; k < NM; k++) begin
      if (grant_o[k]) begin
        bus.s_adr_o = bus.m_adr_i[k*AW +: AW];
        bus.s_dat_o = bus.m_dat_i[k*DW +: DW];
        bus.s_sel_o = bus.m_sel_i[k*4 +: 4];
        bus.s_we_o  = bus.m_we_i[k];
        bus.s_cti_o = bus.m_cti_i[k*3 +: 3];
        bus.s_bte_o = bus.m_bte_i[k*2 +: 2];
      end
    end
    bus.s_cyc_o = (state == GRANT) & gcyc;
    bus.s_stb_o = (state == GRANT) & gcyc & gstb;
  end

  // Route slave responses to the granted master only. A watchdog expiry
  // sends err to that master. Read data is broadcast to every master.
  always_comb begin
    bus.m_dat_o = bus.s_dat_i;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    bus.m_rty_o = '0;
    if (state == GRANT) begin
      bus.m_ack_o = grant_o & {NM{bus.s_ack_i}};
      bus.m_err_o = grant_o & {NM{bus.s_err_i}};
      bus.m_rty_o = grant_o & {NM{bus.s_rty_i}};
    end else if (state == TOUT) begin
      bus.m_err_o = grant_o;
    end
  end

  // Arbitration, grant hold and watchdog state machine.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      grant_o   <= '0;
      last      <= LW'(NM - 1);
      tcnt      <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (|bus.m_cyc_i) begin
            grant_o <= NM'(1) << winner;
            last    <= winner;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (!gcyc) begin
            grant_o <= '0;
            tcnt    <= '0;
            state   <= IDLE;
          end else if ((TIMEOUT > 0) && stall) begin
            if (tcnt == TLAST) begin
              tcnt      <= '0;
              timeout_o <= 1'b1;
              state     <= TOUT;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end else begin
            tcnt <= '0;
          end
        end
        TOUT: begin
          tcnt <= '0;
          if (!gcyc) begin
            grant_o <= '0;
            state   <= IDLE;
          end else begin
            state <= GRANT;
          end
        end
        default: begin
          grant_o <= '0;
          tcnt    <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpsoc_msi_wb_arbiter.sv
// Testbench for mpsoc_msi_wb_arbiter. It runs the directed scenarios
// first, then randomized masters and a randomized slave. Every cycle is
// checked against a transaction-level reference model that tracks only
// the current owner, the last winner and the count of stalled cycles.
`timescale 1ns/1ps
module tb_mpsoc_msi_wb_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NM = 3;
  localparam int TO = 16;
  localparam int BW = AW + DW + 4 + 1 + 3 + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NM-1:0] grant;
  logic          tout;

  always #5 clk = ~clk;

  mpsoc_msi_wb_arbiter_if #(.AW(AW), .DW(DW), .NM(NM)) bus ();

  mpsoc_msi_wb_arbiter #(.AW(AW), .DW(DW), .NM(NM), .TIMEOUT(TO)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .bus       (bus),
    .grant_o   (grant),
    .timeout_o (tout)
  );

  // stimulus state
  logic [AW-1:0] m_adr [NM];
  logic [DW-1:0] m_dat [NM];
  logic [3:0]    m_sel [NM];
  logic          m_we  [NM];
  logic          m_cyc [NM];
  logic          m_stb [NM];
  logic [2:0]    m_cti [NM];
  logic [1:0]    m_bte [NM];
  logic [DW-1:0] sl_dat;
  logic          sl_ack, sl_err, sl_rty;
  logic          rst_req;
  int            slave_mode;   // 0 manual, 1 ack every strobe, 2 random
  int            hang;

  // reference model
  int            owner;        // -1 when the bus is free
  int            last_w;
  int            stall;
  bit            in_tout;
  logic [NM-1:0] e_grant, e_ack, e_err, e_rty;
  logic          e_cyc, e_stb, e_tout;
  logic [BW-1:0] e_bus;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner   = -1;
    last_w  = NM - 1;
    stall   = 0;
    in_tout = 1'b0;
  endtask

  task automatic clear_masters();
    for (int k = 0; k < NM; k++) begin
      m_adr[k] = '0; m_dat[k] = '0; m_sel[k] = '0; m_we[k] = 1'b0;
      m_cyc[k] = 1'b0; m_stb[k] = 1'b0; m_cti[k] = '0; m_bte[k] = '0;
    end
    sl_ack = 1'b0; sl_err = 1'b0; sl_rty = 1'b0; sl_dat = '0;
  endtask

  function automatic bit model_stb();
    return !rst && owner >= 0 && !in_tout && m_cyc[owner] && m_stb[owner];
  endfunction

  task automatic predict();
    e_grant = '0; e_ack = '0; e_err = '0; e_rty = '0;
    e_cyc = 1'b0; e_stb = 1'b0; e_tout = 1'b0; e_bus = '0;
    if (!rst && owner >= 0) begin
      e_grant = NM'(1) << owner;
      if (in_tout) begin
        e_err  = e_grant;
        e_tout = 1'b1;
      end else begin
        e_cyc = m_cyc[owner];
        e_stb = m_cyc[owner] && m_stb[owner];
        if (sl_ack) e_ack = e_grant;
        if (sl_err) e_err = e_grant;
        if (sl_rty) e_rty = e_grant;
        e_bus = {m_adr[owner], m_dat[owner], m_sel[owner], m_we[owner], m_cti[owner], m_bte[owner]};
      end
    end
  endtask

  task automatic advance();
    bit found;
    if (rst) begin
      model_reset();
    end else if (owner < 0) begin
      found = 1'b0;
      for (int i = 1; i <= NM; i++) begin
        int k;
        k = (last_w + i) % NM;
        if (!found && m_cyc[k]) begin
          found  = 1'b1;
          owner  = k;
          last_w = k;
        end
      end
    end else if (in_tout) begin
      in_tout = 1'b0;
      stall   = 0;
      if (!m_cyc[owner]) owner = -1;
    end else if (!m_cyc[owner]) begin
      owner = -1;
      stall = 0;
    end else if (m_stb[owner] && !(sl_ack || sl_err || sl_rty)) begin
      stall++;
      if (stall == TO) begin
        in_tout = 1'b1;
        stall   = 0;
      end
    end else begin
      stall = 0;
    end
  endtask

  // One bus cycle: drive at the falling edge, check 1ns later, then
  // advance the model to what the next rising edge should produce.
  task automatic step();
    int r;
    @(negedge clk);
    rst = rst_req;
    for (int k = 0; k < NM; k++) begin
      bus.m_adr_i[k*AW +: AW] = m_adr[k];
      bus.m_dat_i[k*DW +: DW] = m_dat[k];
      bus.m_sel_i[k*4 +: 4]   = m_sel[k];
      bus.m_we_i[k]           = m_we[k];
      bus.m_cyc_i[k]          = m_cyc[k];
      bus.m_stb_i[k]          = m_stb[k];
      bus.m_cti_i[k*3 +: 3]   = m_cti[k];
      bus.m_bte_i[k*2 +: 2]   = m_bte[k];
    end
    if (slave_mode == 1) begin
      sl_ack = model_stb(); sl_err = 1'b0; sl_rty = 1'b0; sl_dat = $urandom;
    end else if (slave_mode == 2) begin
      sl_ack = 1'b0; sl_err = 1'b0; sl_rty = 1'b0; sl_dat = $urandom;
      if (model_stb()) begin
        if (hang > 0) hang--;
        else if ($urandom_range(0, 39) == 0) hang = 20;
        else begin
          r = $urandom_range(0, 9);
          if (r < 4) sl_ack = 1'b1;
          else if (r == 4) sl_err = 1'b1;
          else if (r == 5) sl_rty = 1'b1;
        end
      end
    end
    bus.s_dat_i = sl_dat;
    bus.s_ack_i = sl_ack;
    bus.s_err_i = sl_err;
    bus.s_rty_i = sl_rty;
    #1;
    predict();
    chk("grant", grant, e_grant);
    chk("s_cyc", bus.s_cyc_o, e_cyc);
    chk("s_stb", bus.s_stb_o, e_stb);
    chk("m_ack", bus.m_ack_o, e_ack);
    chk("m_err", bus.m_err_o, e_err);
    chk("m_rty", bus.m_rty_o, e_rty);
    chk("timeout", tout, e_tout);
    chk("m_dat", bus.m_dat_o, sl_dat);
    if (!rst && owner >= 0 && !in_tout)
      chk("s_bus", {bus.s_adr_o, bus.s_dat_o, bus.s_sel_o, bus.s_we_o, bus.s_cti_o, bus.s_bte_o}, e_bus);
    advance();
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    step();
    chk("rst_grant", grant, 0);
    chk("rst_scyc", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, tout}, 0);
    chk("rst_resp", {bus.m_ack_o, bus.m_err_o, bus.m_rty_o}, 0);
    chk("rst_sbus", {bus.s_adr_o, bus.s_dat_o, bus.s_sel_o, bus.s_cti_o, bus.s_bte_o}, 0);
    rst_req = 1'b0;
  endtask

  int       exp_g [11] = '{0, 1, 1, 0, 2, 2, 0, 4, 4, 0, 1};
  bit       drop  [NM];
  bit       act   [NM];
  int       beats [NM];
  int       idle_l[NM];
  int       acks;

  initial begin
    rst_req = 1'b1; slave_mode = 0; hang = 0;
    clear_masters();
    model_reset();

    // Master 1 single read, slave answers on the third granted cycle
    do_reset();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h100; m_sel[1] = 4'hf;
    step();
    chk("t1_idle", grant, 3'b000);
    step();
    chk("t1_grant", grant, 3'b010);
    chk("t1_sadr", bus.s_adr_o, 32'h100);
    chk("t1_scyc", bus.s_cyc_o, 1'b1);
    step();
    sl_ack = 1'b1; sl_dat = 32'hDEADBEEF;
    step();
    chk("t1_ack", bus.m_ack_o, 3'b010);
    chk("t1_dat", bus.m_dat_o, 32'hDEADBEEF);
    sl_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    step();
    chk("t1_cyc_drop", bus.s_cyc_o, 1'b0);
    step();
    chk("t1_release", grant, 3'b000);

    // All three masters request from reset, single transfers each
    clear_masters();
    for (int k = 0; k < NM; k++) begin m_cyc[k] = 1'b1; m_stb[k] = 1'b1; drop[k] = 1'b0; end
    do_reset();
    slave_mode = 1;
    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < NM; k++) begin m_cyc[k] = !drop[k]; m_stb[k] = !drop[k]; end
      step();
      chk($sformatf("t2_grant%0d", i), grant, exp_g[i]);
      for (int k = 0; k < NM; k++) drop[k] = e_ack[k];
    end

    // Master 0 burst of four beats while master 2 waits
    clear_masters();
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h200;
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_adr[2] = 32'h300;
    beats[0] = 4; acks = 0;
    for (int i = 0; i < 10 && beats[0] > 0; i++) begin
      m_cti[0] = (beats[0] == 1) ? 3'b111 : 3'b010;
      step();
      if (bus.m_ack_o[0]) begin
        chk("t3_hold", grant, 3'b001);
        chk("t3_cti", bus.s_cti_o, (beats[0] == 1) ? 3'b111 : 3'b010);
        acks++;
        beats[0]--;
        m_adr[0] = m_adr[0] + 4;
      end
    end
    chk("t3_acks", acks, 4);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    step();
    chk("t3_drop_grant", grant, 3'b001);
    chk("t3_drop_cyc", bus.s_cyc_o, 1'b0);
    step();
    chk("t3_gap", grant, 3'b000);
    step();
    chk("t3_next", grant, 3'b100);
    chk("t3_next_adr", bus.s_adr_o, 32'h300);
    m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
    step();

    // Slave never answers master 2: watchdog expiry
    clear_masters();
    slave_mode = 0;
    do_reset();
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_adr[2] = 32'h400;
    step();
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 1) chk("t4_stb", bus.s_stb_o, 1'b1);
    end
    chk("t4_pre_tout", tout, 1'b0);
    chk("t4_pre_err", bus.m_err_o, 3'b000);
    step();
    chk("t4_err", bus.m_err_o, 3'b100);
    chk("t4_tout", tout, 1'b1);
    chk("t4_stb_low", bus.s_stb_o, 1'b0);
    m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
    step();
    chk("t4_after", {tout, bus.s_cyc_o}, 2'b00);
    step();
    chk("t4_idle", grant, 3'b000);

    // Slave answers in the very cycle the watchdog would expire
    clear_masters();
    do_reset();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    step();
    for (int i = 1; i <= 15; i++) step();
    sl_ack = 1'b1; sl_dat = 32'h5A5A1234;
    step();
    chk("t5_ack", bus.m_ack_o, 3'b010);
    chk("t5_noerr", bus.m_err_o, 3'b000);
    chk("t5_notout", tout, 1'b0);
    sl_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    step();
    chk("t5_notout2", tout, 1'b0);
    chk("t5_noerr2", bus.m_err_o, 3'b000);

    // Asynchronous reset in the middle of a master 0 burst
    clear_masters();
    do_reset();
    slave_mode = 1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cti[0] = 3'b010;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    step();
    step();
    step();
    chk("t6_burst", grant, 3'b001);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_grant", grant, 3'b000);
    chk("t6_rst_cyc", bus.s_cyc_o, 1'b0);
    chk("t6_rst_ack", bus.m_ack_o, 3'b000);
    model_reset();
    rst_req = 1'b1;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    step();
    rst_req = 1'b0;
    step();
    chk("t6_idle", grant, 3'b000);
    step();
    chk("t6_m1_first", grant, 3'b010);
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    step();

    // Random masters and slave against the model
    clear_masters();
    slave_mode = 2;
    do_reset();
    for (int k = 0; k < NM; k++) begin act[k] = 1'b0; beats[k] = 0; idle_l[k] = 0; end
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NM; k++) begin
        if (!act[k]) begin
          if (idle_l[k] == 0) begin
            act[k]   = 1'b1;
            beats[k] = $urandom_range(1, 4);
            m_adr[k] = $urandom;
            m_we[k]  = 1'($urandom_range(0, 1));
            m_sel[k] = 4'($urandom);
            m_bte[k] = 2'($urandom);
          end else begin
            idle_l[k]--;
          end
        end
        m_cyc[k] = act[k];
        m_stb[k] = act[k] && ($urandom_range(0, 7) != 0);
        m_cti[k] = (beats[k] > 1) ? 3'b010 : 3'b111;
        m_dat[k] = $urandom;
      end
      step();
      for (int k = 0; k < NM; k++) begin
        if (act[k] && (e_ack[k] || e_err[k] || e_rty[k])) begin
          if (e_ack[k] && beats[k] > 1) begin
            beats[k]--;
            m_adr[k] = m_adr[k] + 4;
          end else begin
            act[k]    = 1'b0;
            idle_l[k] = $urandom_range(0, 5);
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
